// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the dmem_responder slice.
// The optional byte-lane feature is enabled with DMEM_RESPONDER_BYTE_EN_EN.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

    // An access is bad if it is not word aligned or its word index falls past the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between a load/store requester and dmem_responder.
// req_be exists only when DMEM_RESPONDER_BYTE_EN_EN is defined.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_RESPONDER_BYTE_EN_EN
    logic [3:0]  req_be;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        output req_be,
`endif
        output req_valid, output req_we, output req_addr, output req_wdata,
        output rsp_ready,
        input  req_ready, input rsp_valid, input rsp_rdata, input rsp_err
    );

    modport slave (
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        input  req_be,
`endif
        input  req_valid, input req_we, input req_addr, input req_wdata,
        input  rsp_ready,
        output req_ready, output rsp_valid, output rsp_rdata, output rsp_err
    );
endinterface

// File: rtl/dmem_word_array.sv
// DEPTH x 32 word store with a byte-lane synchronous write and a registered read
// whose output register can be cleared between responses.
module dmem_word_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_en,
    input  logic                  acc_we,
    input  logic [WORD_BYTES-1:0] acc_be,
    input  logic [AW-1:0]         acc_idx,
    input  logic [31:0]           acc_wdata,
    input  logic                  rd_clr,
    output logic [31:0]           rd_data
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] cur_word_s;
    logic [31:0] wr_word_s;
    logic [31:0] rd_data_d;
    logic [31:0] rd_data_q;

    // Merge enabled store lanes over the current word contents.
    always_comb begin
        cur_word_s = mem_q[acc_idx];
        wr_word_s  = cur_word_s;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (acc_be[i]) begin
                wr_word_s[8*i +: 8] = acc_wdata[8*i +: 8];
            end else begin
                wr_word_s[8*i +: 8] = cur_word_s[8*i +: 8];
            end
        end
    end

    // Read register: loads capture the word, a clear returns it to zero, else hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (acc_en && !acc_we) begin
            rd_data_d = mem_q[acc_idx];
        end else if (rd_clr) begin
            rd_data_d = 32'h0000_0000;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Storage array, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we) begin
            mem_q[acc_idx] <= wr_word_s;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 32'h0000_0000;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store memory responder with a programmable number of wait states.
// Define DMEM_RESPONDER_BYTE_EN_EN to add per-byte store enables (req_be).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]            state_d, state_q;
    logic [CW-1:0]         cnt_d, cnt_q;
    logic                  we_d, we_q;
    logic [AW-1:0]         idx_d, idx_q;
    logic [31:0]           wdata_d, wdata_q;
    logic [WORD_BYTES-1:0] be_d, be_q;
    logic                  err_d, err_q;
    logic                  req_ready_d, req_ready_q;
    logic                  rsp_valid_d, rsp_valid_q;
    logic                  rsp_err_d, rsp_err_q;

    logic [WORD_BYTES-1:0] req_be_s;
    logic                  new_err_s;
    logic                  acc_en_s;
    logic                  acc_we_s;
    logic [AW-1:0]         acc_idx_s;
    logic [31:0]           acc_wdata_s;
    logic [WORD_BYTES-1:0] acc_be_s;
    logic                  rd_clr_s;
    logic [31:0]           rd_data_s;

`ifdef DMEM_RESPONDER_BYTE_EN_EN
    assign req_be_s = bus.req_be;
`else
    assign req_be_s = {WORD_BYTES{1'b1}};
`endif

    assign new_err_s = addr_err(bus.req_addr, DEPTH);

    // Control FSM; the array access happens on the accepting edge when there are no wait states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        acc_en_s    = 1'b0;
        acc_we_s    = we_q;
        acc_idx_s   = idx_q;
        acc_wdata_s = wdata_q;
        acc_be_s    = be_q;
        rd_clr_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    idx_d       = bus.req_addr[AW+1:2];
                    wdata_d     = bus.req_wdata;
                    be_d        = req_be_s;
                    err_d       = new_err_s;
                    req_ready_d = 1'b0;
                    if (ZERO_WAIT) begin
                        acc_en_s    = !new_err_s;
                        acc_we_s    = bus.req_we;
                        acc_idx_s   = bus.req_addr[AW+1:2];
                        acc_wdata_s = bus.req_wdata;
                        acc_be_s    = req_be_s;
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = new_err_s;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    acc_en_s    = !err_q;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_clr_s    = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = {CW{1'b0}};
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rd_clr_s    = 1'b1;
            end
        endcase
    end

    // Control and captured-request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            we_q        <= 1'b0;
            idx_q       <= {AW{1'b0}};
            wdata_q     <= 32'h0000_0000;
            be_q        <= {WORD_BYTES{1'b0}};
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .rst_n     (reset_n),
        .acc_en    (acc_en_s),
        .acc_we    (acc_we_s),
        .acc_be    (acc_be_s),
        .acc_idx   (acc_idx_s),
        .acc_wdata (acc_wdata_s),
        .rd_clr    (rd_clr_s),
        .rd_data   (rd_data_s)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rd_data_s;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: dut0 uses 2 wait states, dut1 uses none.
// Byte-lane checks run only when DMEM_RESPONDER_BYTE_EN_EN is defined.
module tb_dmem_responder;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    // Issue one request on dut0, scramble req_* after acceptance, return response and latency.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (bus0.req_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        bus0.req_valid = 1'b1;
        bus0.req_we    = we;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        bus0.req_we    = ~we;
        bus0.req_addr  = 32'hFFFF_FFFC;
        bus0.req_wdata = 32'h0BAD_0BAD;
        lat = 1;
        while (bus0.rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        rdata = bus0.rsp_rdata;
        err   = bus0.rsp_err;
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus0.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", bus0.req_ready); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", bus0.rsp_rdata); end
        checks++; if (bus0.rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", bus0.rsp_err); end
        checks++; if (bus1.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready_w0 got=%b exp=1", bus1.req_ready); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL post_rst_idle got=%b%b exp=10", bus0.req_ready, bus0.rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h0000_0064, 32'h0000_0007, rd, er, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL st_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL st_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL st_rdata got=%h exp=0", rd); end
        do_req(1'b0, 32'h0000_0064, 32'h0, rd, er, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0000_0007) begin failures++; $display("FAIL ld_rdata got=%h exp=00000007", rd); end
        checks++; if (bus0.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rdata_cleared got=%h exp=0", bus0.rsp_rdata); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h0000_0000, 32'hCAFE_0000, rd, er, lat);
        do_req(1'b1, 32'h0000_00FC, 32'h1357_9BDF, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_err got=%b exp=0", er); end
        do_req(1'b0, 32'h0000_0065, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
        do_req(1'b1, 32'h0000_0100, 32'h5555_5555, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL range_rdata got=%h exp=0", rd); end
        do_req(1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_0000) begin failures++; $display("FAIL no_corrupt got=%h exp=cafe0000", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL no_corrupt_err got=%b exp=0", er); end
        do_req(1'b0, 32'h0000_00FC, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1357_9BDF) begin failures++; $display("FAIL last_word got=%h exp=13579bdf", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        do_req(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, rd, er, lat);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 32'h0000_0020;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        n = 0;
        while (bus0.rsp_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus0.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus0.rsp_valid); end
            checks++; if (bus0.rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_rdata[%0d] got=%h exp=deadbeef", i, bus0.rsp_rdata); end
            checks++; if (bus0.req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus0.req_ready); end
            @(posedge clk); #1;
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
        checks++; if (bus0.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_clear_valid got=%b exp=0", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0) begin failures++; $display("FAIL bp_clear_rdata got=%h exp=0", bus0.rsp_rdata); end
        checks++; if (bus0.req_ready !== 1'b1) begin failures++; $display("FAIL bp_clear_ready got=%b exp=1", bus0.req_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        do_req(1'b1, 32'h0000_0060, 32'h0000_0000, rd, er, lat);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h0000_0060;
        bus0.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        checks++; if (bus0.req_ready !== 1'b0) begin failures++; $display("FAIL wait_ready got=%b exp=0", bus0.req_ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus0.req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus0.req_ready); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus0.rsp_valid); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h0000_0060, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_discarded got=%h exp=0", rd); end
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 32'h0000_0064;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        n = 0;
        while (bus0.rsp_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (bus0.rsp_rdata !== 32'h0000_0007) begin failures++; $display("FAIL resp_before_rst got=%h exp=00000007", bus0.rsp_rdata); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus0.rsp_valid !== 1'b0) begin failures++; $display("FAIL resp_drop_valid got=%b exp=0", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 32'h0) begin failures++; $display("FAIL resp_drop_rdata got=%h exp=0", bus0.rsp_rdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h0000_0064, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000_0007) begin failures++; $display("FAIL mem_kept got=%h exp=00000007", rd); end
    endtask

    task automatic test_back_to_back();
        logic exp_rv;
        logic exp_rdy;
        checks++; if (bus1.req_ready !== 1'b1) begin failures++; $display("FAIL w0_start_ready got=%b exp=1", bus1.req_ready); end
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'h0000_0010;
        bus1.req_wdata = 32'h0000_BEEF;
        bus1.rsp_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            exp_rv  = (i % 2 == 1);
            exp_rdy = (i % 2 == 0);
            checks++; if (bus1.rsp_valid !== exp_rv) begin failures++; $display("FAIL w0_valid[%0d] got=%b exp=%b", i, bus1.rsp_valid, exp_rv); end
            checks++; if (bus1.req_ready !== exp_rdy) begin failures++; $display("FAIL w0_ready[%0d] got=%b exp=%b", i, bus1.req_ready, exp_rdy); end
        end
        bus1.req_we    = 1'b0;
        bus1.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        checks++; if (bus1.rsp_valid !== 1'b1) begin failures++; $display("FAIL w0_ld_valid got=%b exp=1", bus1.rsp_valid); end
        checks++; if (bus1.rsp_rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL w0_ld_rdata got=%h exp=0000beef", bus1.rsp_rdata); end
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus1.rsp_ready = 1'b0;
        checks++; if (bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL w0_clear got=%b/%h exp=0/0", bus1.rsp_valid, bus1.rsp_rdata);
        end
    endtask

`ifdef DMEM_RESPONDER_BYTE_EN_EN
    task automatic test_byte_en();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bus0.req_be = 4'hF;
        do_req(1'b1, 32'h0000_0030, 32'h1122_3344, rd, er, lat);
        bus0.req_be = 4'b0101;
        do_req(1'b1, 32'h0000_0030, 32'hAABB_CCDD, rd, er, lat);
        bus0.req_be = 4'h0;
        do_req(1'b0, 32'h0000_0030, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
        do_req(1'b1, 32'h0000_0030, 32'hFFFF_FFFF, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL be_zero_err got=%b exp=0", er); end
        bus0.req_be = 4'hF;
        do_req(1'b0, 32'h0000_0030, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL be_zero_noop got=%h exp=11bb33dd", rd); end
    endtask
`endif

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        checks   = 0;
        failures = 0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0; bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0; bus1.rsp_ready = 1'b0;
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        bus0.req_be = 4'hF;
        bus1.req_be = 4'hF;
`endif
        @(posedge clk); @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        test_byte_en();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's load/store port.
- Accepts one word request (read or write) on a valid/ready request channel and inserts a programmable number of wait states.
- Returns read data or a write acknowledgement on a valid/ready response channel.
- Replaces the zero-latency data memory, so multi-cycle core variants can be run against realistic memory timing.

Parameters:
- DEPTH, 64, number of 32-bit words stored; power of two, minimum 2.
- WAIT_CYCLES, 2, wait states between request acceptance and the memory access; 0 is legal.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset values (clk and reset_n as above; reset asserts asynchronously, deasserts synchronously via the flop clear):
  - State IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter 0.
  - Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at edge k, capture we/addr/wdata and compute err.
  - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
  - Go to WAIT with counter = WAIT_CYCLES. If WAIT_CYCLES=0, perform the access at edge k itself and go straight to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - At the edge where the counter equals 1:
    - Perform the access: store commits RAM[addr[31:2]] <= wdata unless err; load registers RAM word into rsp_rdata unless err.
    - Go to RESP.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake edge, go to IDLE, clear rsp_valid, and clear rsp_rdata and rsp_err to 0.
  - A new request is not accepted in the handshake cycle.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge, or 1 cycle when WAIT_CYCLES=0. Throughput: one request per WAIT_CYCLES+2 cycles minimum.
- Errors:
  - Store with err: no RAM change; rsp_err=1.
  - Load with err: rsp_rdata=0; rsp_err=1.
- Write commit is atomic with the access edge. A load to the same address afterwards returns the new data.
- Reset mid-operation:
  - In WAIT: the pending access is discarded, and a store not yet committed never commits.
  - In RESP: the response is dropped.
- req_* inputs are sampled only at the accepting edge; changes afterwards are ignored.
- rsp_ready while rsp_valid=0 is ignored.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1.

Optional Feature:
- Macro: DMEM_RESPONDER_BYTE_EN_EN.
- With the macro defined:
  - Adds input req_be[3:0], sampled at acceptance.
  - Stores write only the bytes whose lanes are set; lane i maps to bits 8i+7:8i.
  - req_be=0 is a legal no-op store with a normal, error-free response.
  - Loads ignore req_be.
- Without the macro: the port is absent and all stores write the full word.

Decomposition:
- Package dmem_responder_pkg holds:
  - state enum typedef {IDLE, WAIT, RESP};
  - WORD_BYTES=4 constant;
  - function addr_err(addr, depth).
- Sub-module dmem_word_array: DEPTH x 32 storage with a synchronous write port (with optional byte lanes) and a registered read.

Test Plan:
- Store 0x00000007 to 0x64, then load 0x64 with WAIT_CYCLES=2 -> store response at accept+3 cycles with rsp_err=0 and rsp_rdata=0; load returns rsp_rdata=0x00000007.
- Load 0x65 (misaligned) and store 0x100 with DEPTH=64 (out of range) -> rsp_err=1 and rsp_rdata=0 for both; a follow-up load of 0x00 shows no corruption.
- Hold rsp_ready=0 for 5 cycles during a load of a word preloaded with 0xDEADBEEF -> rsp_valid stays high with rsp_rdata stable at 0xDEADBEEF and req_ready=0; clears one cycle after rsp_ready=1.
- Drive reset_n low in WAIT during a store of 0x12345678 to 0x60 (preloaded 0x0) -> all outputs return to reset values immediately; a load of 0x60 after reset returns 0x0.
- Run with WAIT_CYCLES=0 and back-to-back req_valid -> one accept every 2 cycles; rsp_valid one cycle after each accept.
- With DMEM_RESPONDER_BYTE_EN_EN defined: store 0xAABBCCDD with req_be=4'b0101 over 0x11223344 -> reload returns 0x11BB33DD.
